sar_sequencer: RTL and testbench
================================

Name: sar_sequencer

Overview:
Scheduler that sequences the 10-bit SAR conversion core across NCH analog-mux channels in round-robin order. It inserts offset calibrations on request, at first enable and every CAL_PERIOD conversions. It drives the core's en/cal inputs and the mux select, and captures each result. Results are presented on a valid/ready stream tagged with the channel number.

Parameters:
NCH, 4, number of mux channels (2..16)
CHW, 2, channel index width (clog2(NCH))
CAL_PERIOD, 64, data conversions between automatic calibrations (>=1)
TIMEOUT, 63, max cycles waiting for core valid before abort (covers ~45-cycle calibration)

Ports:
clk  in  1  clock (same clock as SAR core)
rstn  in  1  reset
enable  in  1  run sequencer; low = finish current op then idle
ch_mask  in  NCH  channel enable mask, sampled at each SELECT
cal_req  in  1  one-cycle pulse, request calibration
adc_en  out  1  to core en; one-cycle pulse
adc_cal  out  1  to core cal; valid only while adc_en=1
adc_valid  in  1  core valid (level; high from core Done until next en accepted)
adc_result  in  10  core result
ch_sel  out  CHW  analog mux select
data  out  10  result
data_ch  out  CHW  channel of data
data_valid  out  1  stream valid
data_ready  in  1  stream ready
busy  out  1  state != IDLE
cal_busy  out  1  calibration in flight
err_timeout  out  1  sticky; cleared only by reset

Behaviour:
- Reset (async, active-low): reset rstn, asynchronous, active-low; clock clk. All outputs 0; state SETTLE; ch_sel=0; conv counter=0; cal_pending=1; rr pointer = NCH-1, so the first data slot is ch 0.
- SETTLE: 2 cycles unconditionally (core passes through its init state), then IDLE.
- IDLE: if enable=1 and (cal_pending or ch_mask!=0) -> SELECT; else stay. enable rising edge sets cal_pending.
- SELECT (1 cycle): if cal_pending -> cal op, ch_sel unchanged. Else pick the next set bit of ch_mask after the rr pointer, wrapping at NCH-1 -> 0. Drive ch_sel, update the pointer. If mask==0, return to IDLE. Then -> ISSUE. ch_sel stays stable from this cycle through WAIT_HI (mux settling).
- ISSUE (1 cycle): adc_en=1, adc_cal=cal op; cal_busy=1 for cal op; clear timeout counter -> WAIT_LO.
- WAIT_LO: wait adc_valid=0 (core clears it on accepting en) -> WAIT_HI.
- WAIT_HI: on adc_valid=1:
  - cal op: clear cal_pending, conv counter=0, cal_busy=0 -> IDLE check.
  - data op: latch adc_result into data/data_ch, data_valid=1, conv counter+1 -> OUT.
- Timeout: timeout counter runs in WAIT_LO/WAIT_HI. Reaching TIMEOUT sets err_timeout, drops the op (no data; cal_pending kept), cal_busy=0 -> IDLE.
- OUT: hold data/data_ch/data_valid until data_ready=1; clear data_valid on the handshake cycle. No new ISSUE while data_valid=1 (backpressure, never overwrite). Then -> IDLE check. If conv counter == CAL_PERIOD, set cal_pending.
- cal_req arriving in any state sets cal_pending; it is serviced at the next SELECT, never aborting an op in flight. cal_req coincident with counter wrap: a single calibration.
- enable dropped mid-op: op completes (including OUT handshake), then IDLE.
- ch_mask changes take effect only at SELECT.
- Single enabled channel: converts the same channel back to back.

Optional Feature:
SARSEQ_AVG_EN:
- Defined: each data slot issues 4 conversions on the same ch_sel (re-entering ISSUE after each WAIT_HI). Results accumulate into a 12-bit sum; data = sum[11:2]. conv counter increments once per slot. A timeout drops the whole slot.
- Undefined: one conversion per slot.

Test Plan:
- Reset, enable=1, mask=4'b0101, core model: after SETTLE, first adc_en has adc_cal=1; then data on ch 0, 2, 0, 2 with data_ch matching and data equal to model results.
- CAL_PERIOD=4, mask=4'b1111: calibration issued after every 4th data handshake; conv counter resets; cal_busy high only during cal op.
- data_ready held low 100 cycles after a result: data/data_valid stable, adc_en stays 0; ready=1 -> next conversion issued within 3 cycles.
- Core model never raises valid: err_timeout=1 after TIMEOUT cycles in wait, no data_valid, sequencer returns to IDLE and retries.
- cal_req pulse mid-conversion plus mask change 0101->1000 mid-op: current op finishes, next op is cal, next data is ch 3; rstn low mid-WAIT_HI: all outputs 0 immediately.
- With SARSEQ_AVG_EN, results 100, 101, 102, 103 -> data = 101, 4 adc_en pulses per slot.

Source files
------------

// File: rtl/sar_sequencer.sv
// Round-robin scheduler for the 10-bit SAR core: channel select, calibration insertion, result stream.
// Optional build macro SARSEQ_AVG_EN: four conversions per data slot, averaged into one result.
module sar_sequencer #(
    parameter int NCH        = 4,
    parameter int CHW        = 2,
    parameter int CAL_PERIOD = 64,
    parameter int TIMEOUT    = 63
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           enable,
    input  logic [NCH-1:0] ch_mask,
    input  logic           cal_req,
    output logic           adc_en,
    output logic           adc_cal,
    input  logic           adc_valid,
    input  logic [9:0]     adc_result,
    output logic [CHW-1:0] ch_sel,
    output logic [9:0]     data,
    output logic [CHW-1:0] data_ch,
    output logic           data_valid,
    input  logic           data_ready,
    output logic           busy,
    output logic           cal_busy,
    output logic           err_timeout
);
    localparam int CNT_W = $clog2(CAL_PERIOD + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_SETTLE, S_IDLE, S_SELECT, S_ISSUE, S_WAIT_LO, S_WAIT_HI, S_OUT
    } state_t;

    state_t           state_q, state_d;
    logic             settle_q, settle_d;
    logic             en_prev_q;
    logic             cal_pending_q, cal_pending_d;
    logic             cal_op_q, cal_op_d;
    logic [CHW-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0] conv_q, conv_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             adc_en_q, adc_en_d, adc_cal_q, adc_cal_d;
    logic [CHW-1:0]   ch_sel_q, ch_sel_d, data_ch_q, data_ch_d;
    logic [9:0]       data_q, data_d;
    logic             data_valid_q, data_valid_d;
    logic             busy_q, busy_d, cal_busy_q, cal_busy_d, err_q, err_d;
`ifdef SARSEQ_AVG_EN
    logic [11:0]      sum_q, sum_d, sum_nx;
    logic [1:0]       avg_cnt_q, avg_cnt_d;
`endif

    logic             en_rise, abort, found, tmo_expired;
    logic [CHW-1:0]   pick;
    logic [CHW:0]     idx;

    assign en_rise     = enable & ~en_prev_q;
    assign tmo_expired = (tmo_q == TMO_W'(TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        settle_d      = settle_q;
        cal_pending_d = cal_pending_q | cal_req | en_rise;
        cal_op_d      = cal_op_q;
        rr_d          = rr_q;
        conv_d        = conv_q;
        tmo_d         = tmo_q;
        ch_sel_d      = ch_sel_q;
        data_d        = data_q;
        data_ch_d     = data_ch_q;
        data_valid_d  = data_valid_q;
        cal_busy_d    = cal_busy_q;
        err_d         = err_q;
        abort         = 1'b0;
`ifdef SARSEQ_AVG_EN
        sum_d         = sum_q;
        avg_cnt_d     = avg_cnt_q;
        sum_nx        = sum_q + {2'b00, adc_result};
`endif
        // First set mask bit strictly after the round-robin pointer, wrapping.
        pick  = rr_q;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NCH; i++) begin
            idx = {1'b0, rr_q} + (CHW+1)'(i);
            if (idx >= (CHW+1)'(NCH)) idx = idx - (CHW+1)'(NCH);
            if (!found && ch_mask[idx[CHW-1:0]]) begin
                found = 1'b1;
                pick  = idx[CHW-1:0];
            end
        end

        case (state_q)
            S_SETTLE: begin
                if (settle_q) state_d = S_IDLE;
                else          settle_d = 1'b1;
            end
            S_IDLE: begin
                if (enable && (cal_pending_q || |ch_mask)) state_d = S_SELECT;
            end
            S_SELECT: begin
`ifdef SARSEQ_AVG_EN
                sum_d     = '0;
                avg_cnt_d = '0;
`endif
                if (cal_pending_q) begin
                    cal_op_d = 1'b1;
                    state_d  = S_ISSUE;
                end else if (found) begin
                    cal_op_d = 1'b0;
                    ch_sel_d = pick;
                    rr_d     = pick;
                    state_d  = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                tmo_d = tmo_q + 1'b1;
                if (!adc_valid)       state_d = S_WAIT_HI;
                else if (tmo_expired) abort = 1'b1;
            end
            S_WAIT_HI: begin
                tmo_d = tmo_q + 1'b1;
                if (adc_valid) begin
                    if (cal_op_q) begin
                        cal_pending_d = cal_req | en_rise;
                        conv_d        = '0;
                        cal_busy_d    = 1'b0;
                        state_d       = (enable && (cal_pending_d || |ch_mask)) ? S_SELECT : S_IDLE;
                    end else begin
`ifdef SARSEQ_AVG_EN
                        if (avg_cnt_q == 2'd3) begin
                            data_d       = sum_nx[11:2];
                            data_ch_d    = ch_sel_q;
                            data_valid_d = 1'b1;
                            conv_d       = conv_q + 1'b1;
                            state_d      = S_OUT;
                        end else begin
                            sum_d     = sum_nx;
                            avg_cnt_d = avg_cnt_q + 2'd1;
                            state_d   = S_ISSUE;
                        end
`else
                        data_d       = adc_result;
                        data_ch_d    = ch_sel_q;
                        data_valid_d = 1'b1;
                        conv_d       = conv_q + 1'b1;
                        state_d      = S_OUT;
`endif
                    end
                end else if (tmo_expired) begin
                    abort = 1'b1;
                end
            end
            S_OUT: begin
                if (data_ready) begin
                    data_valid_d = 1'b0;
                    if (conv_q == CNT_W'(CAL_PERIOD)) cal_pending_d = 1'b1;
                    state_d = (enable && (cal_pending_d || |ch_mask)) ? S_SELECT : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A timed-out op is dropped whole; a pending calibration stays pending.
        if (abort) begin
            err_d      = 1'b1;
            cal_busy_d = 1'b0;
            state_d    = S_IDLE;
`ifdef SARSEQ_AVG_EN
            avg_cnt_d  = '0;
            sum_d      = '0;
`endif
        end

        adc_en_d  = (state_d == S_ISSUE);
        adc_cal_d = adc_en_d & cal_op_d;
        if (adc_en_d && cal_op_d) cal_busy_d = 1'b1;
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_SETTLE;
            settle_q      <= 1'b0;
            en_prev_q     <= 1'b0;
            cal_pending_q <= 1'b1;
            cal_op_q      <= 1'b0;
            rr_q          <= CHW'(NCH - 1);
            conv_q        <= '0;
            tmo_q         <= '0;
            adc_en_q      <= 1'b0;
            adc_cal_q     <= 1'b0;
            ch_sel_q      <= '0;
            data_q        <= '0;
            data_ch_q     <= '0;
            data_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            cal_busy_q    <= 1'b0;
            err_q         <= 1'b0;
`ifdef SARSEQ_AVG_EN
            sum_q         <= '0;
            avg_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            settle_q      <= settle_d;
            en_prev_q     <= enable;
            cal_pending_q <= cal_pending_d;
            cal_op_q      <= cal_op_d;
            rr_q          <= rr_d;
            conv_q        <= conv_d;
            tmo_q         <= tmo_d;
            adc_en_q      <= adc_en_d;
            adc_cal_q     <= adc_cal_d;
            ch_sel_q      <= ch_sel_d;
            data_q        <= data_d;
            data_ch_q     <= data_ch_d;
            data_valid_q  <= data_valid_d;
            busy_q        <= busy_d;
            cal_busy_q    <= cal_busy_d;
            err_q         <= err_d;
`ifdef SARSEQ_AVG_EN
            sum_q         <= sum_d;
            avg_cnt_q     <= avg_cnt_d;
`endif
        end
    end

    assign adc_en      = adc_en_q;
    assign adc_cal     = adc_cal_q;
    assign ch_sel      = ch_sel_q;
    assign data        = data_q;
    assign data_ch     = data_ch_q;
    assign data_valid  = data_valid_q;
    assign busy        = busy_q;
    assign cal_busy    = cal_busy_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_sar_sequencer.sv
// Bench for sar_sequencer: behavioural SAR core, scheduling model and result scoreboard.
// Stream handshake: a result transfers on a rising edge where data_valid and data_ready are both 1.
module tb_sar_sequencer;
  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam int CAL_PERIOD = 4;
  localparam int TIMEOUT = 63;
  localparam int W = CHW + 10;

  logic clk, rstn, enable, cal_req, adc_valid, data_ready;
  logic [NCH-1:0] ch_mask;
  logic adc_en, adc_cal, data_valid, busy, cal_busy, err_timeout;
  logic [9:0] adc_result, data;
  logic [CHW-1:0] ch_sel, data_ch;

  sar_sequencer #(.NCH(NCH), .CHW(CHW), .CAL_PERIOD(CAL_PERIOD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .ch_mask(ch_mask), .cal_req(cal_req),
    .adc_en(adc_en), .adc_cal(adc_cal), .adc_valid(adc_valid), .adc_result(adc_result),
    .ch_sel(ch_sel), .data(data), .data_ch(data_ch), .data_valid(data_valid),
    .data_ready(data_ready), .busy(busy), .cal_busy(cal_busy), .err_timeout(err_timeout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // scoreboard and model state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_e;
  int model_rr, model_conv, cur_ch, core_cnt, avg_k, avg_sum, nxt;
  bit model_pend, cur_cal, core_dead, rand_ready, err_prev, exp_cal, hit;
  int n_hs = 0;
  int n_cal = 0;

  always @(negedge clk) begin
    #1;
    if (!rstn) begin
      model_rr = NCH - 1; model_pend = 1'b1; model_conv = 0; core_cnt = 0;
      adc_valid = 1'b0; exp_q.delete(); avg_k = 0; avg_sum = 0; err_prev = 1'b0;
    end else begin
      if (err_timeout && !err_prev) begin avg_k = 0; avg_sum = 0; end
      err_prev = err_timeout;
      if (adc_en) begin
        exp_cal = (avg_k == 0) ? model_pend : 1'b0;
        check("adc_cal", adc_cal, exp_cal);
        check("cal_busy_at_issue", cal_busy, exp_cal);
        cur_cal = exp_cal;
        if (exp_cal) n_cal++;
        else begin
          if (avg_k == 0) begin
            hit = 1'b0; nxt = -1;
            for (int k = 1; k <= NCH; k++) begin
              if (!hit && ch_mask[(model_rr + k) % NCH]) begin hit = 1'b1; nxt = (model_rr + k) % NCH; end
            end
            model_rr = nxt; cur_ch = nxt;
          end
          check("ch_sel", ch_sel, cur_ch);
        end
        adc_valid = 1'b0;
        if (!core_dead) core_cnt = exp_cal ? 20 : $urandom_range(3, 8);
      end else if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          adc_valid = 1'b1;
          if (cur_cal) begin
            adc_result = 10'($urandom_range(0, 1023));
            model_pend = 1'b0; model_conv = 0;
          end else begin
`ifdef SARSEQ_AVG_EN
            adc_result = 10'(100 + avg_k);
            avg_sum += 100 + avg_k;
            avg_k++;
            if (avg_k == 4) begin
              exp_q.push_back({CHW'(cur_ch), 10'(avg_sum >> 2)});
              avg_k = 0; avg_sum = 0; model_conv++;
            end
`else
            adc_result = 10'($urandom_range(0, 1023));
            exp_q.push_back({CHW'(cur_ch), adc_result});
            model_conv++;
`endif
          end
        end
      end
      if (cal_req) model_pend = 1'b1;
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) check("unexpected_data", 1, 0);
        else begin
          sb_e = exp_q.pop_front();
          check("data", data, sb_e[9:0]);
          check("data_ch", data_ch, sb_e[W-1:10]);
        end
        n_hs++;
        if (model_conv == CAL_PERIOD) model_pend = 1'b1;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
    if (rand_ready) data_ready = ($urandom_range(0, 3) != 0);
    #2;
  endtask

  task automatic wait_en(input string tag);
    int n = 0;
    step();
    while (!adc_en && n < 300) begin step(); n++; end
    check(tag, adc_en, 1);
  endtask

  task automatic wait_hs(input int cnt, input string tag);
    int target = n_hs + cnt;
    int n = 0;
    while (n_hs < target && n < 3000) begin step(); n++; end
    check(tag, n_hs >= target, 1);
  endtask

  task automatic wait_data_en();
    wait_en("sync_en");
    while (adc_cal) wait_en("sync_data_en");
  endtask

  initial begin
    int c0, cnt, bad;
    logic [9:0] hold_d;
    logic [CHW-1:0] hold_ch;
    rstn = 1'b0; enable = 1'b1; ch_mask = 4'b0101; cal_req = 1'b0;
    data_ready = 1'b1; core_dead = 1'b0; rand_ready = 1'b0;
    adc_valid = 1'b0; adc_result = '0;
    step();
    check("rst_outputs", {adc_en, adc_cal, ch_sel, data, data_ch, data_valid, busy, cal_busy, err_timeout}, 0);
    step();
    rstn = 1'b1;

    // first op after settle is a calibration, then ch 0,2,0,2
    wait_en("first_en");
    check("first_is_cal", adc_cal, 1);
    wait_hs(4, "t1_hs");

    // periodic calibration with all channels and random backpressure
    ch_mask = 4'b1111; rand_ready = 1'b1; c0 = n_cal;
    wait_hs(12, "t2_hs");
    check("cal_count", n_cal - c0, 3);

    // hold ready low for 100 cycles
    rand_ready = 1'b0; data_ready = 1'b0; cnt = 0;
    while (!data_valid && cnt < 300) begin step(); cnt++; end
    check("bp_valid_seen", data_valid, 1);
    hold_d = data; hold_ch = data_ch; bad = 0;
    repeat (100) begin
      step();
      if (data !== hold_d || data_ch !== hold_ch || data_valid !== 1'b1 || adc_en !== 1'b0) bad++;
    end
    check("bp_stable", bad, 0);
    data_ready = 1'b1; cnt = 0;
    while (!adc_en && cnt < 10) begin step(); cnt++; end
    check("bp_restart_fast", (adc_en && cnt <= 3), 1);

    // dead core: timeout, drop, retry
    core_dead = 1'b1;
    wait_en("dead_en");
    cnt = 0; bad = 0;
    while (!err_timeout && cnt < 200) begin step(); cnt++; if (data_valid) bad++; end
    check("timeout_cycles", cnt, TIMEOUT + 1);
    check("timeout_no_data", bad, 0);
    check("timeout_idle", busy, 0);
    core_dead = 1'b0;
    wait_hs(2, "retry_hs");
    check("err_sticky", err_timeout, 1);

    // cal_req and mask change during a data op
    wait_data_en();
    step(); step();
    cal_req = 1'b1; ch_mask = 4'b1000;
    step();
    cal_req = 1'b0;
    wait_en("req_en");
    check("cal_after_req", adc_cal, 1);
    wait_en("mask_en");
    check("mask_ch3", ch_sel, 3);
    wait_hs(2, "t5_hs");

    // asynchronous reset while waiting on the core
    wait_data_en();
    step(); step();
    rstn = 1'b0;
    #1;
    check("rst_mid_outputs", {adc_en, adc_cal, ch_sel, data, data_ch, data_valid, busy, cal_busy, err_timeout}, 0);
    ch_mask = 4'b0101;
    step(); step();
    rstn = 1'b1;
    wait_en("post_rst_en");
    check("post_rst_cal", adc_cal, 1);
    wait_hs(3, "t6_hs");
    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
